// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin share of the register-file write port among NREQ write-back sources.
// Latency: grant is combinational in cycle N, the write is presented registered in cycle N+1; 1 write/cycle.
// Backpressure: wb_stall or reset withholds every req_ready; define RF_WB_SCOREBOARD_EN for the pending-write scoreboard.
module rf_wb_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned IDW  = 2,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 wb_stall,
    output logic                 rg_wrt_en,
    output logic [AW-1:0]        rg_wrt_addr,
    output logic [DW-1:0]        rg_wrt_data,
    output logic [IDW-1:0]       grant_id,
    input  logic                 sb_set_en,
    input  logic [AW-1:0]        sb_set_addr,
    output logic [(2**AW)-1:0]   sb_busy
);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_req_t;

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] gid_q, gid_d;
    logic           en_q, en_d;
    wb_req_t        wr_q, wr_d;

    logic           win_vld;
    logic [IDW-1:0] win_idx;
    logic [IDW-1:0] cand_idx;
    int unsigned    cand;
    wb_req_t        win_req;

    // Search starts one past the last winner so every source gets a turn.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand     = (32'(ptr_q) + k) % NREQ;
            cand_idx = IDW'(cand);
            if (!win_vld && req_valid[cand_idx]) begin
                win_vld = 1'b1;
                win_idx = cand_idx;
            end
        end
        if (reset || wb_stall) begin
            win_vld = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        if (win_vld) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        win_req.addr = req_addr[win_idx*AW +: AW];
        win_req.data = req_data[win_idx*DW +: DW];
    end

    // x0 writes are consumed and advance the pointer but never reach the file.
    always_comb begin
        ptr_d = ptr_q;
        gid_d = gid_q;
        wr_d  = wr_q;
        en_d  = 1'b0;
        if (win_vld) begin
            ptr_d = win_idx;
            gid_d = win_idx;
            wr_d  = win_req;
            en_d  = |win_req.addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= IDW'(NREQ - 1);
            gid_q <= '0;
            en_q  <= 1'b0;
            wr_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            gid_q <= gid_d;
            en_q  <= en_d;
            wr_q  <= wr_d;
        end
    end

    assign rg_wrt_en   = en_q;
    assign rg_wrt_addr = wr_q.addr;
    assign rg_wrt_data = wr_q.data;
    assign grant_id    = gid_q;

`ifdef RF_WB_SCOREBOARD_EN
    logic [(2**AW)-1:0] sb_q, sb_d;

    // Clear on the presented write first so a same-edge set wins.
    always_comb begin
        sb_d = sb_q;
        if (en_q) begin
            sb_d[wr_q.addr] = 1'b0;
        end
        if (sb_set_en && (sb_set_addr != '0)) begin
            sb_d[sb_set_addr] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign sb_busy = sb_q;
`else
    logic unused_sb;
    assign unused_sb = ^{sb_set_en, sb_set_addr};
    assign sb_busy   = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus a randomized run against a round-robin reference model.
module tb_rf_wb_arbiter;
    localparam int NREQ = 3;
    localparam int IDW  = 2;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int SBW  = 2**AW;
`ifdef RF_WB_SCOREBOARD_EN
    localparam bit SB_ON = 1'b1;
`else
    localparam bit SB_ON = 1'b0;
`endif

    logic                clk;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic                wb_stall;
    logic                rg_wrt_en;
    logic [AW-1:0]       rg_wrt_addr;
    logic [DW-1:0]       rg_wrt_data;
    logic [IDW-1:0]      grant_id;
    logic                sb_set_en;
    logic [AW-1:0]       sb_set_addr;
    logic [SBW-1:0]      sb_busy;

    rf_wb_arbiter #(.NREQ(NREQ), .IDW(IDW), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .wb_stall(wb_stall),
        .rg_wrt_en(rg_wrt_en), .rg_wrt_addr(rg_wrt_addr), .rg_wrt_data(rg_wrt_data),
        .grant_id(grant_id),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .sb_busy(sb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Reference model state: last winner, registered write, scoreboard bits.
    int              m_ptr;
    int              m_gid;
    logic            m_en;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_data;
    logic [SBW-1:0]  m_sb;
    logic [NREQ-1:0] obs_rdy;
    logic [NREQ-1:0] exp_rdy;

    function automatic logic [NREQ-1:0] model_ready();
        logic [NREQ-1:0] r;
        int i;
        r = '0;
        if (reset || wb_stall) return r;
        for (int k = 1; k <= NREQ; k++) begin
            i = (m_ptr + k) % NREQ;
            if (req_valid[i]) begin
                r[i] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr  = NREQ - 1;
        m_gid  = 0;
        m_en   = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_sb   = '0;
    endtask

    task automatic model_edge(input logic [NREQ-1:0] rdy);
        logic [SBW-1:0] sb;
        int w;
        sb = m_sb;
        if (SB_ON) begin
            if (m_en) sb[m_addr] = 1'b0;
            if (sb_set_en && sb_set_addr != 0) sb[sb_set_addr] = 1'b1;
        end
        w = onehot_idx(rdy);
        if (w >= 0) begin
            m_ptr  = w;
            m_gid  = w;
            m_addr = req_addr[w*AW +: AW];
            m_data = req_data[w*DW +: DW];
            m_en   = (m_addr != 0);
        end else begin
            m_en = 1'b0;
        end
        m_sb = sb;
    endtask

    // Sample ready mid-cycle, advance the model, then cross one rising edge.
    task automatic step();
        #1;
        obs_rdy = req_ready;
        exp_rdy = model_ready();
        model_edge(exp_rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        req_valid   = '0;
        req_addr    = '0;
        req_data    = '0;
        wb_stall    = 1'b0;
        sb_set_en   = 1'b0;
        sb_set_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = '0; req_addr = '0; req_data = '0;
        wb_stall = 1'b0; sb_set_en = 1'b0; sb_set_addr = '0;
        @(posedge clk);
        #1;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), DW'(32'hA0 + i));
        #2;
        checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset_ready got=%b exp=%b", req_ready, 3'b000); end
        checks++; if (rg_wrt_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", rg_wrt_en); end
        checks++; if (rg_wrt_addr !== '0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", rg_wrt_addr); end
        checks++; if (rg_wrt_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", rg_wrt_data); end
        checks++; if (grant_id !== '0) begin failures++; $display("FAIL reset_gid got=%0d exp=0", grant_id); end
        checks++; if (sb_busy !== '0) begin failures++; $display("FAIL reset_sb got=%h exp=0", sb_busy); end
        req_valid = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 5'd5, 32'hDEADBEEF);
        req_valid = 3'b001;
        step();
        req_valid = '0;
        checks++; if (obs_rdy !== 3'b001) begin failures++; $display("FAIL single_ready got=%b exp=001", obs_rdy); end
        checks++; if (rg_wrt_en !== 1'b1) begin failures++; $display("FAIL single_en got=%b exp=1", rg_wrt_en); end
        checks++; if (rg_wrt_addr !== 5'd5) begin failures++; $display("FAIL single_addr got=%0d exp=5", rg_wrt_addr); end
        checks++; if (rg_wrt_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data got=%h exp=deadbeef", rg_wrt_data); end
        checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL single_gid got=%0d exp=0", grant_id); end
        step();
        checks++; if (rg_wrt_en !== 1'b0) begin failures++; $display("FAIL idle_en got=%b exp=0", rg_wrt_en); end
        checks++; if (rg_wrt_addr !== 5'd5 || rg_wrt_data !== 32'hDEADBEEF) begin failures++; $display("FAIL idle_hold got=%0d/%h exp=5/deadbeef", rg_wrt_addr, rg_wrt_data); end
    endtask

    task automatic test_back_to_back();
        int order[6] = '{0, 1, 2, 0, 1, 2};
        logic [DW-1:0] sent;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(10 + i), $urandom);
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            sent = req_data[order[c]*DW +: DW];
            step();
            checks++; if (obs_rdy !== 3'(1 << order[c])) begin failures++; $display("FAIL b2b_ready[%0d] got=%b exp_id=%0d", c, obs_rdy, order[c]); end
            checks++; if (grant_id !== IDW'(order[c])) begin failures++; $display("FAIL b2b_gid[%0d] got=%0d exp=%0d", c, grant_id, order[c]); end
            checks++; if (rg_wrt_en !== 1'b1 || rg_wrt_data !== sent) begin failures++; $display("FAIL b2b_write[%0d] got=%b/%h exp=1/%h", c, rg_wrt_en, rg_wrt_data, sent); end
            set_req(order[c], AW'(10 + order[c]), $urandom);
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_x0();
        do_reset();
        set_req(0, 5'd3, 32'h3333);
        req_valid = 3'b001;
        step();
        set_req(1, 5'd0, 32'h1234);
        req_valid = 3'b010;
        step();
        checks++; if (obs_rdy !== 3'b010) begin failures++; $display("FAIL x0_ready got=%b exp=010", obs_rdy); end
        checks++; if (rg_wrt_en !== 1'b0) begin failures++; $display("FAIL x0_en got=%b exp=0", rg_wrt_en); end
        checks++; if (grant_id !== 2'd1) begin failures++; $display("FAIL x0_gid got=%0d exp=1", grant_id); end
        set_req(0, 5'd4, 32'h4444);
        set_req(1, 5'd8, 32'h8888);
        set_req(2, 5'd6, 32'h6666);
        req_valid = 3'b111;
        step();
        checks++; if (obs_rdy !== 3'b100 || grant_id !== 2'd2) begin failures++; $display("FAIL x0_next got=%b/%0d exp=100/2", obs_rdy, grant_id); end
        checks++; if (rg_wrt_en !== 1'b1 || rg_wrt_addr !== 5'd6) begin failures++; $display("FAIL x0_next_wr got=%b/%0d exp=1/6", rg_wrt_en, rg_wrt_addr); end
        req_valid = '0;
        step();
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(20 + i), DW'(32'h500 + i));
        req_valid = 3'b111;
        step();
        checks++; if (obs_rdy !== 3'b001) begin failures++; $display("FAIL stall_first got=%b exp=001", obs_rdy); end
        wb_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (obs_rdy !== 3'b000 || rg_wrt_en !== 1'b0) begin failures++; $display("FAIL stall_hold[%0d] got=%b/%b exp=000/0", c, obs_rdy, rg_wrt_en); end
            checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL stall_gid[%0d] got=%0d exp=0", c, grant_id); end
        end
        wb_stall = 1'b0;
        step();
        checks++; if (obs_rdy !== 3'b010 || grant_id !== 2'd1) begin failures++; $display("FAIL stall_resume got=%b/%0d exp=010/1", obs_rdy, grant_id); end
        req_valid = '0;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(0, 5'd7, 32'h7777);
        req_valid = 3'b001;
        step();
        req_valid = 3'b111;
        checks++; if (rg_wrt_en !== 1'b1) begin failures++; $display("FAIL rmid_pre_en got=%b exp=1", rg_wrt_en); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (rg_wrt_en !== 1'b0) begin failures++; $display("FAIL rmid_en got=%b exp=0", rg_wrt_en); end
        checks++; if (grant_id !== 2'd0 || rg_wrt_addr !== 5'd0) begin failures++; $display("FAIL rmid_regs got=%0d/%0d exp=0/0", grant_id, rg_wrt_addr); end
        checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL rmid_ready got=%b exp=000", req_ready); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        set_req(0, 5'd7, 32'h7777);
        step();
        checks++; if (obs_rdy !== 3'b001 || grant_id !== 2'd0) begin failures++; $display("FAIL rmid_ptr got=%b/%0d exp=001/0", obs_rdy, grant_id); end
        req_valid = '0;
        step();
    endtask

    task automatic test_scoreboard();
        do_reset();
        sb_set_en = 1'b1; sb_set_addr = 5'd9;
        step();
        sb_set_en = 1'b0;
        checks++; if (sb_busy[9] !== SB_ON) begin failures++; $display("FAIL sb_set got=%b exp=%b", sb_busy[9], SB_ON); end
        step();
        checks++; if (sb_busy[9] !== SB_ON) begin failures++; $display("FAIL sb_hold got=%b exp=%b", sb_busy[9], SB_ON); end
        set_req(0, 5'd9, 32'h9999);
        req_valid = 3'b001;
        step();
        req_valid = '0;
        checks++; if (rg_wrt_en !== 1'b1 || sb_busy[9] !== SB_ON) begin failures++; $display("FAIL sb_pending got=%b/%b exp=1/%b", rg_wrt_en, sb_busy[9], SB_ON); end
        step();
        checks++; if (sb_busy[9] !== 1'b0) begin failures++; $display("FAIL sb_clear got=%b exp=0", sb_busy[9]); end
        sb_set_en = 1'b1; sb_set_addr = 5'd9;
        step();
        sb_set_en = 1'b0;
        req_valid = 3'b001;
        step();
        req_valid = '0;
        sb_set_en = 1'b1; sb_set_addr = 5'd9;
        step();
        sb_set_en = 1'b0;
        checks++; if (sb_busy[9] !== SB_ON) begin failures++; $display("FAIL sb_set_wins got=%b exp=%b", sb_busy[9], SB_ON); end
        checks++; if (sb_busy !== m_sb) begin failures++; $display("FAIL sb_vec got=%h exp=%h", sb_busy, m_sb); end
        do_reset();
        sb_set_en = 1'b1; sb_set_addr = 5'd0;
        step();
        sb_set_en = 1'b0;
        checks++; if (sb_busy !== '0) begin failures++; $display("FAIL sb_x0 got=%h exp=0", sb_busy); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            wb_stall    = ($urandom_range(0, 4) == 0);
            sb_set_en   = ($urandom_range(0, 3) == 0);
            sb_set_addr = AW'($urandom);
            step();
            checks++; if (obs_rdy !== exp_rdy) begin failures++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", c, obs_rdy, exp_rdy); end
            checks++; if (rg_wrt_en !== m_en) begin failures++; $display("FAIL rnd_en[%0d] got=%b exp=%b", c, rg_wrt_en, m_en); end
            checks++; if (rg_wrt_addr !== m_addr || rg_wrt_data !== m_data) begin failures++; $display("FAIL rnd_wr[%0d] got=%0d/%h exp=%0d/%h", c, rg_wrt_addr, rg_wrt_data, m_addr, m_data); end
            checks++; if (grant_id !== IDW'(m_gid)) begin failures++; $display("FAIL rnd_gid[%0d] got=%0d exp=%0d", c, grant_id, m_gid); end
            checks++; if (sb_busy !== m_sb) begin failures++; $display("FAIL rnd_sb[%0d] got=%h exp=%h", c, sb_busy, m_sb); end
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || exp_rdy[i]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        req_valid[i] = 1'b1;
                        set_req(i, ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom), $urandom);
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        req_valid = '0;
        wb_stall  = 1'b0;
        sb_set_en = 1'b0;
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_x0();
        test_stall();
        test_reset_mid();
        test_scoreboard();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
